mem_copy_ctrl: RTL and testbench

- Sequencer and arbiter in front of the single-port 256x8 data memory (combinational read, clocked write).
- Shares the memory between the CPU load/store port and an internal block-copy engine that moves Length bytes from SrcAddr to DstAddr.
- CPU has priority; a bounded-stall guard guarantees copy progress.
- Sits between the CPU datapath and the memory; drives every memory control and address pin.

---
 rtl/mem_copy_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_copy_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_ctrl.sv
// mem_copy_ctrl: sequencer and arbiter in front of a single-port 256x8 data
// memory. It shares the memory between the CPU load/store port and a
// byte-wise block-copy engine. The CPU wins every cycle unless the engine has
// been starved MAX_STALL cycles in a row. In that case the engine takes
// exactly one memory cycle.
module mem_copy_ctrl #(
    parameter int unsigned MAX_STALL = 4,
    parameter int unsigned STALL_W   = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [7:0] SrcAddr,
    input  logic [7:0] DstAddr,
    input  logic [7:0] Length,
    input  logic       CpuReq,
    input  logic       CpuWriteEn,
    input  logic [7:0] CpuAddr,
    input  logic [7:0] CpuWData,
    output logic       CpuGrant,
    output logic [7:0] CpuRData,
    output logic       MemReadEn,
    output logic       MemWriteEn,
    output logic [7:0] MemAddr,
    output logic [7:0] MemDataIn,
    input  logic [7:0] MemDataOut,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       src_q, src_d;
    logic [AW-1:0]       dst_q, dst_d;
    logic [AW-1:0]       len_q, len_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       hold_q, hold_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                busy_q, done_q;

    logic                engine_want;
    logic                force_engine;
    logic                engine_own;
    logic                eng_rd, eng_wr;
    logic [AW-1:0]       eng_addr;

    // Arbitration: the CPU has priority unless the stall guard has tripped.
    always_comb begin
        engine_want  = (state_q == S_RD) || (state_q == S_WR);
        force_engine = engine_want && (MAX_STALL != 0) && (stall_q == STALL_LIMIT);
        CpuGrant     = CpuReq && !force_engine;
        engine_own   = engine_want && !CpuGrant;
    end

    // Copy sequencer: next state and the engine's memory request.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        eng_rd   = 1'b0;
        eng_wr   = 1'b0;
        eng_addr = '0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    src_d   = SrcAddr;
                    dst_d   = DstAddr;
                    len_d   = Length;
                    idx_d   = '0;
                    state_d = (Length == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (engine_own) begin
                    eng_rd   = 1'b1;
                    eng_addr = AW'(src_q + idx_q);
                    hold_d   = MemDataOut;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                if (engine_own) begin
                    eng_wr   = 1'b1;
                    eng_addr = AW'(dst_q + idx_q);
                    idx_d    = AW'(idx_q + AW'(1));
                    state_d  = (AW'(idx_q + AW'(1)) == len_q) ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall counter: counts consecutive starved engine cycles, saturating.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) || engine_own) begin
            stall_d = '0;
        end else if (engine_want && CpuGrant && (stall_q != STALL_LIMIT)) begin
            stall_d = STALL_W'(stall_q + STALL_W'(1));
        end
    end

    // Memory pin mux: CPU, engine, or all-zero when nobody owns the memory.
    always_comb begin
        MemReadEn  = 1'b0;
        MemWriteEn = 1'b0;
        MemAddr    = '0;
        MemDataIn  = '0;
        if (CpuGrant) begin
            MemReadEn  = !CpuWriteEn;
            MemWriteEn = CpuWriteEn;
            MemAddr    = CpuAddr;
            MemDataIn  = CpuWData;
        end else if (eng_rd) begin
            MemReadEn  = 1'b1;
            MemAddr    = eng_addr;
        end else if (eng_wr) begin
            MemWriteEn = 1'b1;
            MemAddr    = eng_addr;
            MemDataIn  = hold_q;
        end
    end

    // CPU read data is only presented on a granted CPU read.
    always_comb begin
        CpuRData = (CpuGrant && !CpuWriteEn) ? MemDataOut : '0;
    end

    // State and datapath registers; Busy/Done are registered from next state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            stall_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            stall_q <= stall_d;
            busy_q  <= (state_d == S_RD) || (state_d == S_WR);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Bench for mem_copy_ctrl: a behavioural 256x8 memory, plus a transaction-level
// model. The model counts the remaining engine memory operations and applies
// the grant rule from the consecutive-starvation count.
module tb_mem_copy_ctrl;

    localparam int unsigned MAX_STALL = 4;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic [7:0] SrcAddr, DstAddr, Length;
    logic       CpuReq, CpuWriteEn;
    logic [7:0] CpuAddr, CpuWData;
    logic       CpuGrant;
    logic [7:0] CpuRData;
    logic       MemReadEn, MemWriteEn;
    logic [7:0] MemAddr, MemDataIn, MemDataOut;
    logic       Busy, Done;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    mem_copy_ctrl #(.MAX_STALL(MAX_STALL), .STALL_W(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
        .CpuReq(CpuReq), .CpuWriteEn(CpuWriteEn), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGrant(CpuGrant), .CpuRData(CpuRData),
        .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn), .MemAddr(MemAddr),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Single-port memory: combinational read, clocked write.
    assign MemDataOut = mem[MemAddr];
    always @(posedge Clk) if (MemWriteEn) mem[MemAddr] <= MemDataIn;

    task automatic set_mem(input logic [7:0] a, input logic [7:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    // Runs one copy against the model. Returns per-cycle mismatch count and the
    // observed Done cycle and Busy cycle count (relative to the Start edge).
    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                            input int req_pct, input int wr_pct, input int cpu_mode, input bit restart,
                            output int errs, output int done_obs, output int busy_obs);
        int ops_left, run, j, bound;
        bit fin;
        logic [7:0] hold, idx8;
        logic exp_grant, exp_re, exp_we;
        logic [7:0] exp_addr, exp_din, exp_rdata;
        logic [28:0] got, exp;
        errs = 0; done_obs = -1; busy_obs = 0;
        hold = 8'h00;
        @(negedge Clk);
        Start = 1'b1; SrcAddr = src; DstAddr = dst; Length = len; CpuReq = 1'b0;
        #1;
        if (Busy !== 1'b0 || Done !== 1'b0) errs++;
        ops_left = 2 * int'(len);
        run = 0;
        fin = 1'b0;
        bound = 2 * int'(len) * (int'(MAX_STALL) + 1) + 2;
        for (int c = 1; c <= bound && !fin; c++) begin
            @(negedge Clk);
            if (restart && ops_left > 0) begin
                Start = 1'b1; SrcAddr = 8'($urandom); DstAddr = dst ^ 8'h55; Length = 8'($urandom);
            end else begin
                Start = 1'b0; SrcAddr = src; DstAddr = dst; Length = len;
            end
            if (cpu_mode == 1) begin
                CpuReq = 1'b1; CpuWriteEn = 1'b1; CpuAddr = 8'h80; CpuWData = 8'h5A;
            end else begin
                CpuReq     = ($urandom_range(99, 0) < req_pct);
                CpuWriteEn = ($urandom_range(99, 0) < wr_pct);
                CpuAddr    = 8'($urandom);
                CpuWData   = 8'($urandom);
            end
            #1;
            if (Done === 1'b1 && done_obs < 0) done_obs = c;
            if (Busy === 1'b1) busy_obs++;
            exp_grant = CpuReq && !(ops_left > 0 && MAX_STALL != 0 && run == int'(MAX_STALL));
            j = 2 * int'(len) - ops_left;
            idx8 = 8'(j / 2);
            exp_re = 1'b0; exp_we = 1'b0; exp_addr = 8'h00; exp_din = 8'h00;
            if (exp_grant) begin
                exp_re = !CpuWriteEn; exp_we = CpuWriteEn; exp_addr = CpuAddr; exp_din = CpuWData;
            end else if (ops_left > 0) begin
                if (j % 2 == 0) begin
                    exp_re = 1'b1; exp_addr = src + idx8;
                end else begin
                    exp_we = 1'b1; exp_addr = dst + idx8; exp_din = hold;
                end
            end
            exp_rdata = (exp_grant && !CpuWriteEn) ? ref_mem[CpuAddr] : 8'h00;
            got = {Busy, Done, CpuGrant, MemReadEn, MemWriteEn, MemAddr, MemDataIn, CpuRData};
            exp = {ops_left > 0, ops_left == 0, exp_grant, exp_re, exp_we, exp_addr, exp_din, exp_rdata};
            if (got !== exp) begin
                errs++;
                if (errs <= 3)
                    $display("note: cycle %0d pins got %h expected %h", c, got, exp);
            end
            if (exp_grant && CpuWriteEn) ref_mem[CpuAddr] = CpuWData;
            if (ops_left == 0) begin
                fin = 1'b1;
            end else if (exp_grant) begin
                run = (run < int'(MAX_STALL)) ? run + 1 : run;
            end else begin
                if (j % 2 == 0) hold = ref_mem[src + idx8];
                else ref_mem[dst + idx8] = hold;
                run = 0;
                ops_left--;
            end
        end
        if (!fin) errs++;
        @(negedge Clk);
        Start = 1'b0; CpuReq = 1'b0;
        #1;
        if ({Busy, Done, MemReadEn, MemWriteEn} !== 4'b0000) errs++;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Start = 1'b0; SrcAddr = 8'h00; DstAddr = 8'h00; Length = 8'h00;
        CpuReq = 1'b1; CpuWriteEn = 1'b0; CpuAddr = 8'h33; CpuWData = 8'h00;
        #3;
        n_checks++;
        if ({Busy, Done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: busy/done %b required 00", {Busy, Done});
        end
        n_checks++;
        if ({CpuGrant, MemReadEn, MemWriteEn, MemAddr, CpuRData} !== {3'b110, 8'h33, ref_mem[8'h33]}) begin
            n_fail++; $display("FAIL reset_cpu_path: grant=%b re=%b we=%b addr=%h rdata=%h required 1 1 0 33 %h",
                               CpuGrant, MemReadEn, MemWriteEn, MemAddr, CpuRData, ref_mem[8'h33]);
        end
        CpuReq = 1'b0;
        #1;
        n_checks++;
        if ({CpuGrant, MemReadEn, MemWriteEn, MemAddr, MemDataIn} !== 19'h0) begin
            n_fail++; $display("FAIL reset_idle_pins: %h required 0", {CpuGrant, MemReadEn, MemWriteEn, MemAddr, MemDataIn});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int errs, d, b;
        set_mem(8'h10, 8'hA1); set_mem(8'h11, 8'hB2); set_mem(8'h12, 8'hC3); set_mem(8'h13, 8'hD4);
        run_copy(8'h10, 8'h40, 8'd4, 0, 0, 0, 1'b0, errs, d, b);
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL basic_cycles: %0d cycle mismatches, required 0", errs); end
        n_checks++;
        if (d !== 9 || b !== 8) begin n_fail++; $display("FAIL basic_latency: done@%0d busy=%0d required done@9 busy=8", d, b); end
        n_checks++;
        if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hA1B2C3D4) begin
            n_fail++; $display("FAIL basic_data: %h required A1B2C3D4", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]});
        end
        n_checks++;
        if (mem_diff() !== 0) begin n_fail++; $display("FAIL basic_mem: %0d bytes differ, required 0", mem_diff()); end
    endtask

    task automatic test_len_zero();
        int errs, d, b;
        run_copy(8'h10, 8'h40, 8'd0, 0, 0, 0, 1'b0, errs, d, b);
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL len0_cycles: %0d cycle mismatches, required 0", errs); end
        n_checks++;
        if (d !== 1 || b !== 0) begin n_fail++; $display("FAIL len0_latency: done@%0d busy=%0d required done@1 busy=0", d, b); end
        n_checks++;
        if (mem_diff() !== 0) begin n_fail++; $display("FAIL len0_mem: %0d bytes differ, required 0", mem_diff()); end
    endtask

    task automatic test_wrap();
        int errs, d, b;
        set_mem(8'hFE, 8'h11); set_mem(8'hFF, 8'h22); set_mem(8'h00, 8'h33);
        run_copy(8'hFE, 8'h01, 8'd3, 0, 0, 0, 1'b0, errs, d, b);
        n_checks++;
        if (errs !== 0 || d !== 7) begin n_fail++; $display("FAIL wrap_cycles: errs=%0d done@%0d required 0 and 7", errs, d); end
        n_checks++;
        if ({mem[8'h01], mem[8'h02], mem[8'h03]} !== 24'h112233) begin
            n_fail++; $display("FAIL wrap_data: %h required 112233", {mem[8'h01], mem[8'h02], mem[8'h03]});
        end
    endtask

    task automatic test_stall_guard();
        int errs, d, b;
        set_mem(8'h20, 8'h9C); set_mem(8'h21, 8'h3E); set_mem(8'h22, 8'h71);
        run_copy(8'h20, 8'hA0, 8'd3, 100, 100, 1, 1'b0, errs, d, b);
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL stall_cycles: %0d cycle mismatches, required 0", errs); end
        n_checks++;
        if (d !== 31 || b !== 30) begin n_fail++; $display("FAIL stall_latency: done@%0d busy=%0d required done@31 busy=30", d, b); end
        n_checks++;
        if (mem[8'h80] !== 8'h5A) begin n_fail++; $display("FAIL stall_cpu_write: mem[80]=%h required 5A", mem[8'h80]); end
        n_checks++;
        if ({mem[8'hA0], mem[8'hA1], mem[8'hA2]} !== 24'h9C3E71) begin
            n_fail++; $display("FAIL stall_data: %h required 9C3E71", {mem[8'hA0], mem[8'hA1], mem[8'hA2]});
        end
    endtask

    task automatic test_reset_midcopy();
        int errs, d, b;
        logic [7:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = 8'($urandom_range(255, 1));
            set_mem(8'(8'h50 + i), v[i]);
            set_mem(8'(8'h60 + i), 8'h00);
        end
        @(negedge Clk);
        Start = 1'b1; SrcAddr = 8'h50; DstAddr = 8'h60; Length = 8'd4; CpuReq = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        #1;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Done, MemWriteEn} !== 3'b000) begin
            n_fail++; $display("FAIL midreset_flags: busy/done/we %b required 000", {Busy, Done, MemWriteEn});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        n_checks++;
        if ({Busy, Done} !== 2'b00) begin n_fail++; $display("FAIL midreset_after: busy/done %b required 00", {Busy, Done}); end
        ref_mem[8'h60] = v[0];
        ref_mem[8'h61] = v[1];
        n_checks++;
        if (mem_diff() !== 0) begin n_fail++; $display("FAIL midreset_mem: %0d bytes differ, required 0 (bytes 0-1 only)", mem_diff()); end
        run_copy(8'h50, 8'h60, 8'd4, 0, 0, 0, 1'b0, errs, d, b);
        n_checks++;
        if (errs !== 0 || d !== 9 || mem_diff() !== 0) begin
            n_fail++; $display("FAIL midreset_recopy: errs=%0d done@%0d diff=%0d required 0, 9, 0", errs, d, mem_diff());
        end
    endtask

    task automatic test_restart_ignored();
        int errs, d, b;
        run_copy(8'h10, 8'h90, 8'd5, 0, 0, 0, 1'b1, errs, d, b);
        n_checks++;
        if (errs !== 0 || d !== 11) begin n_fail++; $display("FAIL restart_cycles: errs=%0d done@%0d required 0 and 11", errs, d); end
        n_checks++;
        if (mem_diff() !== 0) begin n_fail++; $display("FAIL restart_mem: %0d bytes differ, required 0", mem_diff()); end
    endtask

    task automatic test_random();
        int errs, d, b;
        for (int it = 0; it < 8; it++) begin
            run_copy(8'($urandom), 8'($urandom), 8'($urandom_range(40, 1)),
                     int'($urandom_range(90, 0)), int'($urandom_range(50, 0)), 0, 1'b0, errs, d, b);
            n_checks++;
            if (errs !== 0) begin n_fail++; $display("FAIL random_cycles[%0d]: %0d cycle mismatches, required 0", it, errs); end
            n_checks++;
            if (mem_diff() !== 0) begin n_fail++; $display("FAIL random_mem[%0d]: %0d bytes differ, required 0", it, mem_diff()); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) set_mem(8'(i), 8'($urandom));
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_stall_guard();
        test_reset_midcopy();
        test_restart_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
